cam_table_writer: RTL and testbench
===================================

Name: cam_table_writer

Overview:
- Control-plane writer for the key/value lookup table: the CAM maps key to index, and the 16x32 RAM maps index to value.
- Accepts one table-update request at a time, either write-entry or invalidate-entry.
- Sequences the CAM write port (WE/WR_ADDR/DIN/DATA_MASK, honouring BUSY) and the RAM axi-side write port.
- Orders the two writes so the datapath lookup (CAM MATCH_ADDR -> RAM axis read) never returns a new key paired with a stale value.

Parameters:
- C_DEPTH, 16: number of table entries.
- C_WIDTH, 4: CAM key width.
- ADDR_W, 4: index width, clog2(C_DEPTH).
- DATA_W, 32: RAM value width.
- INVALID_KEY, {C_WIDTH{1'b1}}: key written to the CAM on invalidate; reserved, never looked up.
- BUSY_TIMEOUT, 255: maximum cycles spent waiting for cam_busy low before the request aborts.

Ports:
- axi_clk  in  1  clock, all logic posedge.
- axi_rst  in  1  synchronous active-high reset.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted when high together with req_valid.
- req_op  in  1  0 = write entry, 1 = invalidate entry.
- req_index  in  ADDR_W  table index.
- req_key  in  C_WIDTH  key; ignored when req_op = 1.
- req_value  in  DATA_W  value; ignored when req_op = 1.
- cam_we  out  1  CAM write enable.
- cam_wr_addr  out  ADDR_W  CAM write address.
- cam_din  out  C_WIDTH  CAM write key.
- cam_data_mask  out  C_WIDTH  tied 0 (exact match).
- cam_busy  in  1  CAM BUSY.
- ram_wr_en  out  1  RAM axi_wr_en.
- ram_addr  out  ADDR_W  RAM axi_addr.
- ram_data  out  DATA_W  RAM axi_data_in.
- done  out  1  one-cycle pulse: request completed.
- err  out  1  one-cycle pulse: request rejected or aborted.

Behaviour:
- Reset values: req_ready=0, cam_we=0, ram_wr_en=0, done=0, err=0, cam_wr_addr/cam_din/ram_addr/ram_data=0.
  - Reset asserted at any point: state returns to IDLE the next cycle and the latched request is discarded.
  - A half-written entry is not repaired; software rewrites it.
- Outputs are registered and Moore-decoded from state. req_ready=1 only in IDLE.
- States: IDLE, RAM_WR, WAIT_BUSY, CAM_WR, CAM_SKIP, CAM_WAIT, RAM_CLR, DONE, ERR.
- IDLE:
  - On req_valid&req_ready, latch op/index/key/value.
  - If index >= C_DEPTH, go to ERR; no write is issued.
  - Else if op=0, go to RAM_WR; if op=1, go to WAIT_BUSY.
- Write sequence (value before key): RAM_WR -> WAIT_BUSY -> CAM_WR -> CAM_SKIP -> CAM_WAIT -> DONE.
- Invalidate sequence (key before value): WAIT_BUSY -> CAM_WR (cam_din=INVALID_KEY) -> CAM_SKIP -> CAM_WAIT -> RAM_CLR -> DONE.
- RAM_WR: ram_wr_en=1 for exactly 1 cycle, ram_addr=index, ram_data=value.
- RAM_CLR: ram_wr_en=1 for 1 cycle, ram_data=0.
- WAIT_BUSY / CAM_WAIT:
  - Leave when cam_busy=0 is sampled.
  - A wait counter, cleared on entry, increments every cycle cam_busy=1.
  - When the counter reaches BUSY_TIMEOUT, go to ERR.
- CAM_WR: cam_we=1 for exactly 1 cycle, cam_wr_addr=index. Asserted only in a cycle where cam_busy was sampled 0 in the previous cycle.
- CAM_SKIP: 1 cycle; covers the BUSY assertion delay after WE.
- DONE: done=1 for 1 cycle, then IDLE.
- ERR: err=1 for 1 cycle, then IDLE.
  - Timeout in CAM_WAIT during invalidate skips RAM_CLR.
  - Timeout during write leaves the RAM value written but the CAM not updated (harmless: no key points to it).
- cam_we and ram_wr_en are never high in the same cycle.
- Latency, cam_busy held 0: accept at T.
  - Write: ram_wr_en at T+1, cam_we at T+3, done at T+6.
  - Invalidate: cam_we at T+2, ram_wr_en at T+5, done at T+6.
- Back-to-back requests: the next one is accepted no earlier than the cycle after DONE/ERR (req_ready high again in IDLE).

Test Plan:
- Write, busy=0: op=0, idx=3, key=4'h5, val=32'hDEADBEEF.
  - ram_wr_en at T+1 with addr=3, data=DEADBEEF.
  - cam_we at T+3 with addr=3, din=5.
  - done at T+6.
  - Downstream: CMP_DIN=5 -> MATCH=1, MATCH_ADDR=3, RAM read=DEADBEEF.
- Busy stall: cam_busy=1 for 10 cycles during WAIT_BUSY.
  - cam_we delayed exactly 10 cycles; no cam_we while busy; done still single pulse.
- Invalidate idx=3: cam_we with din=F precedes ram_wr_en with data=0; afterwards CMP_DIN=5 -> MATCH=0.
- Timeout: cam_busy stuck 1.
  - err pulses after BUSY_TIMEOUT cycles; no cam_we; req_ready returns 1.
- Out of range: with C_DEPTH=12, idx=13 -> err at T+1; no ram_wr_en or cam_we issued.
- Reset mid-op: assert axi_rst in the cycle after ram_wr_en.
  - All strobes 0 the next cycle; no done/err; req_ready=1 one cycle after reset release.

Source files
------------

// File: rtl/cam_table_writer.sv
// cam_table_writer: sequences CAM key and RAM value writes for one table entry
// so a lookup never pairs a new key with a stale value.
module cam_table_writer #(
   parameter int                 C_DEPTH      = 16,
   parameter int                 C_WIDTH      = 4,
   parameter int                 ADDR_W       = 4,
   parameter int                 DATA_W       = 32,
   parameter logic [C_WIDTH-1:0] INVALID_KEY  = {C_WIDTH{1'b1}},
   parameter int                 BUSY_TIMEOUT = 255
) (
   input  logic              axi_clk,
   input  logic              axi_rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_op,
   input  logic [ADDR_W-1:0] req_index,
   input  logic [C_WIDTH-1:0] req_key,
   input  logic [DATA_W-1:0] req_value,
   output logic              cam_we,
   output logic [ADDR_W-1:0] cam_wr_addr,
   output logic [C_WIDTH-1:0] cam_din,
   output logic [C_WIDTH-1:0] cam_data_mask,
   input  logic              cam_busy,
   output logic              ram_wr_en,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_data,
   output logic              done,
   output logic              err
);

   localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_TIMEOUT - 1);

   typedef enum logic [3:0] {
      S_IDLE,
      S_RAM_WR,
      S_WAIT_BUSY,
      S_CAM_WR,
      S_CAM_SKIP,
      S_CAM_WAIT,
      S_RAM_CLR,
      S_DONE,
      S_ERR
   } state_e;

   state_e               state_q, state_d;
   logic                 op_q, op_d;
   logic [ADDR_W-1:0]    idx_q, idx_d;
   logic [C_WIDTH-1:0]   key_q, key_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 ready_q, ready_d;
   logic                 cam_we_q, cam_we_d;
   logic                 ram_we_q, ram_we_d;
   logic                 done_q, done_d;
   logic                 err_q, err_d;
   logic [ADDR_W-1:0]    cam_addr_q, cam_addr_d;
   logic [C_WIDTH-1:0]   cam_din_q, cam_din_d;
   logic [ADDR_W-1:0]    ram_addr_q, ram_addr_d;
   logic [DATA_W-1:0]    ram_data_q, ram_data_d;
   logic                 idx_bad;

   assign idx_bad = {1'b0, req_index} >= (ADDR_W + 1)'(C_DEPTH);

   // Next state, request latch, wait counter and registered output decode
   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      idx_d      = idx_q;
      key_d      = key_q;
      cnt_d      = cnt_q;
      cam_addr_d = cam_addr_q;
      cam_din_d  = cam_din_q;
      ram_addr_d = ram_addr_q;
      ram_data_d = ram_data_q;

      unique case (state_q)
         S_IDLE: begin
            if (req_valid && ready_q) begin
               op_d  = req_op;
               idx_d = req_index;
               key_d = req_key;
               cnt_d = '0;
               if (idx_bad)     state_d = S_ERR;
               else if (req_op) state_d = S_WAIT_BUSY;
               else             state_d = S_RAM_WR;
            end
         end
         S_RAM_WR: begin
            cnt_d   = '0;
            state_d = S_WAIT_BUSY;
         end
         S_WAIT_BUSY: begin
            if (!cam_busy)             state_d = S_CAM_WR;
            else if (cnt_q == CNT_LAST) state_d = S_ERR;
            else                       cnt_d = cnt_q + CNT_W'(1);
         end
         S_CAM_WR: state_d = S_CAM_SKIP;
         S_CAM_SKIP: begin
            cnt_d   = '0;
            state_d = S_CAM_WAIT;
         end
         S_CAM_WAIT: begin
            if (!cam_busy)             state_d = op_q ? S_RAM_CLR : S_DONE;
            else if (cnt_q == CNT_LAST) state_d = S_ERR;
            else                       cnt_d = cnt_q + CNT_W'(1);
         end
         S_RAM_CLR: state_d = S_DONE;
         S_DONE:    state_d = S_IDLE;
         S_ERR:     state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase

      ready_d  = (state_d == S_IDLE);
      cam_we_d = (state_d == S_CAM_WR);
      ram_we_d = (state_d == S_RAM_WR) || (state_d == S_RAM_CLR);
      done_d   = (state_d == S_DONE);
      err_d    = (state_d == S_ERR);

      if (state_d == S_CAM_WR) begin
         cam_addr_d = idx_q;
         cam_din_d  = op_q ? INVALID_KEY : key_q;
      end
      // RAM_WR is only entered straight from IDLE, so take the live request
      if (state_d == S_RAM_WR) begin
         ram_addr_d = req_index;
         ram_data_d = req_value;
      end else if (state_d == S_RAM_CLR) begin
         ram_addr_d = idx_q;
         ram_data_d = '0;
      end
   end

   // State, latched request and output registers with synchronous reset
   always_ff @(posedge axi_clk) begin
      if (axi_rst) begin
         state_q    <= S_IDLE;
         op_q       <= 1'b0;
         idx_q      <= '0;
         key_q      <= '0;
         cnt_q      <= '0;
         ready_q    <= 1'b0;
         cam_we_q   <= 1'b0;
         ram_we_q   <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         cam_addr_q <= '0;
         cam_din_q  <= '0;
         ram_addr_q <= '0;
         ram_data_q <= '0;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         idx_q      <= idx_d;
         key_q      <= key_d;
         cnt_q      <= cnt_d;
         ready_q    <= ready_d;
         cam_we_q   <= cam_we_d;
         ram_we_q   <= ram_we_d;
         done_q     <= done_d;
         err_q      <= err_d;
         cam_addr_q <= cam_addr_d;
         cam_din_q  <= cam_din_d;
         ram_addr_q <= ram_addr_d;
         ram_data_q <= ram_data_d;
      end
   end

   assign req_ready     = ready_q;
   assign cam_we        = cam_we_q;
   assign cam_wr_addr   = cam_addr_q;
   assign cam_din       = cam_din_q;
   assign cam_data_mask = '0;
   assign ram_wr_en     = ram_we_q;
   assign ram_addr      = ram_addr_q;
   assign ram_data      = ram_data_q;
   assign done          = done_q;
   assign err           = err_q;

endmodule

// File: tb/tb_cam_table_writer.sv
// tb_cam_table_writer: directed and random table updates checked against
// an event-schedule model and a shadow of the CAM/RAM contents.
module tb_cam_table_writer;

   localparam int DEPTH = 12;
   localparam int TO    = 255;
   localparam logic [3:0] INV = 4'hF;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_op = 1'b0;
   logic [3:0]  req_index = '0;
   logic [3:0]  req_key = '0;
   logic [31:0] req_value = '0;
   logic        cam_we;
   logic [3:0]  cam_wr_addr;
   logic [3:0]  cam_din;
   logic [3:0]  cam_data_mask;
   logic        cam_busy = 1'b0;
   logic        ram_wr_en;
   logic [3:0]  ram_addr;
   logic [31:0] ram_data;
   logic        done;
   logic        err;

   int errors = 0;
   int checks = 0;

   logic [3:0]  sh_key [16] = '{default: 4'hF};
   logic [31:0] sh_val [16] = '{default: 32'h0};
   logic [3:0]  mk [16] = '{default: 4'hF};
   logic [31:0] mv [16] = '{default: 32'h0};

   cam_table_writer #(
      .C_DEPTH(DEPTH), .C_WIDTH(4), .ADDR_W(4), .DATA_W(32),
      .INVALID_KEY(INV), .BUSY_TIMEOUT(TO)
   ) dut (
      .axi_clk(clk), .axi_rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .req_index(req_index),
      .req_key(req_key), .req_value(req_value),
      .cam_we(cam_we), .cam_wr_addr(cam_wr_addr),
      .cam_din(cam_din), .cam_data_mask(cam_data_mask),
      .cam_busy(cam_busy),
      .ram_wr_en(ram_wr_en), .ram_addr(ram_addr), .ram_data(ram_data),
      .done(done), .err(err)
   );

   always #5 clk = ~clk;

   // Shadow of what the CAM and RAM would hold after the DUT's writes
   always @(negedge clk) begin
      if (cam_we)    sh_key[cam_wr_addr] <= cam_din;
      if (ram_wr_en) sh_val[ram_addr]    <= ram_data;
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // First cycle >= s with busy low, or -1 if TO busy cycles elapse first
   function automatic int wait_end(int s, int bs, int be);
      if (s >= bs && s < be) begin
         if (be - s >= TO) return -1;
         return be;
      end
      return s;
   endfunction

   function automatic bit key_hit(logic [3:0] k);
      for (int i = 0; i < 16; i++)
         if (sh_key[i] == k) return 1'b1;
      return 1'b0;
   endfunction

   task automatic run(input logic op, input logic [3:0] idx,
                      input logic [3:0] key, input logic [31:0] val,
                      input int bs, input int be);
      int ram_c, cam_c, done_c, err_c, end_c, w1, w2;
      logic [31:0] ram_exp;
      logic [3:0]  din_exp;
      ram_c = -1; cam_c = -1; done_c = -1; err_c = -1;
      ram_exp = '0;
      din_exp = op ? INV : key;
      if (int'(idx) >= DEPTH) begin
         err_c = 1;
      end else if (!op) begin
         ram_c = 1; ram_exp = val;
         w1 = wait_end(2, bs, be);
         if (w1 < 0) err_c = 2 + TO;
         else begin
            cam_c = w1 + 1;
            w2 = wait_end(w1 + 3, bs, be);
            if (w2 < 0) err_c = w1 + 3 + TO;
            else done_c = w2 + 1;
         end
      end else begin
         w1 = wait_end(1, bs, be);
         if (w1 < 0) err_c = 1 + TO;
         else begin
            cam_c = w1 + 1;
            w2 = wait_end(w1 + 3, bs, be);
            if (w2 < 0) err_c = w1 + 3 + TO;
            else begin
               ram_c = w2 + 1;
               done_c = w2 + 2;
            end
         end
      end
      end_c = (done_c > 0) ? done_c : err_c;
      if (ram_c > 0) mv[idx] = ram_exp;
      if (cam_c > 0) mk[idx] = din_exp;

      chk("ready_at_issue", 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_op = op; req_index = idx;
      req_key = key; req_value = val; cam_busy = 1'b0;
      for (int k = 1; k <= end_c + 1; k++) begin
         @(posedge clk); #1;
         req_valid = 1'b0;
         cam_busy = (k >= bs && k < be);
         @(negedge clk);
         chk("cam_we", 32'(cam_we), 32'(k == cam_c));
         chk("ram_wr_en", 32'(ram_wr_en), 32'(k == ram_c));
         chk("done", 32'(done), 32'(k == done_c));
         chk("err", 32'(err), 32'(k == err_c));
         chk("req_ready", 32'(req_ready), 32'(k == end_c + 1));
         chk("mask", 32'(cam_data_mask), 32'd0);
         if (k == cam_c) begin
            chk("cam_addr", 32'(cam_wr_addr), 32'(idx));
            chk("cam_din", 32'(cam_din), 32'(din_exp));
         end
         if (k == ram_c) begin
            chk("ram_addr", 32'(ram_addr), 32'(idx));
            chk("ram_data", ram_data, ram_exp);
         end
      end
      cam_busy = 1'b0;
      chk("tbl_key", 32'(sh_key[idx]), 32'(mk[idx]));
      chk("tbl_val", sh_val[idx], mv[idx]);
   endtask

   initial begin
      int bs, be;
      @(negedge clk);
      chk("rst_ready", 32'(req_ready), 32'd0);
      chk("rst_strobes", {28'd0, cam_we, ram_wr_en, done, err}, 32'd0);
      chk("rst_data", {cam_wr_addr, cam_din, ram_addr, 20'd0}, 32'd0);
      chk("rst_ram_data", ram_data, 32'd0);
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("ready_first", 32'(req_ready), 32'd0);
      @(negedge clk);
      chk("ready_second", 32'(req_ready), 32'd1);

      run(1'b0, 4'd3, 4'h5, 32'hDEADBEEF, 0, 0);
      chk("lookup_5_hit", 32'(key_hit(4'h5)), 32'd1);
      chk("lookup_5_val", sh_val[3], 32'hDEADBEEF);
      run(1'b0, 4'd7, 4'h9, 32'h0BAD_F00D, 2, 12);
      run(1'b1, 4'd3, 4'h0, 32'h0, 0, 0);
      chk("lookup_5_miss", 32'(key_hit(4'h5)), 32'd0);
      run(1'b1, 4'd7, 4'h0, 32'h0, 3, 9);
      run(1'b0, 4'd2, 4'h6, 32'h1111_2222, 1, 1000);
      run(1'b1, 4'd4, 4'h0, 32'h0, 4, 4 + TO + 2);
      run(1'b0, 4'd13, 4'h1, 32'h5555_AAAA, 0, 0);
      run(1'b0, 4'd11, 4'h2, 32'h7777_8888, 0, 0);

      // Reset in the cycle after ram_wr_en of a write
      req_valid = 1'b1; req_op = 1'b0; req_index = 4'd5;
      req_key = 4'h2; req_value = 32'h0000_1234;
      @(posedge clk); #1 req_valid = 1'b0;
      @(negedge clk);
      chk("mid_ram_we", 32'(ram_wr_en), 32'd1);
      mv[5] = 32'h0000_1234;
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("mid_strobes", {28'd0, cam_we, ram_wr_en, done, err}, 32'd0);
      chk("mid_ready_lo", 32'(req_ready), 32'd0);
      @(negedge clk);
      chk("mid_ready_hi", 32'(req_ready), 32'd1);
      chk("mid_no_pulse", {30'd0, done, err}, 32'd0);
      chk("mid_key", 32'(sh_key[5]), 32'(mk[5]));
      chk("mid_val", sh_val[5], mv[5]);

      for (int i = 0; i < 40; i++) begin
         bs = 0; be = 0;
         if ($urandom_range(0, 2) != 0) begin
            bs = $urandom_range(1, 8);
            be = bs + $urandom_range(1, 12);
         end
         run(1'($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)),
             4'($urandom_range(0, 14)), $urandom, bs, be);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
